// File: rtl/led_drv_pkg.sv
// Shared constants and helpers for the daisy-chained LED shift driver.
package led_drv_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DIV    = 2;

    // Cycles from the accept edge until the driver is ready again.
    localparam int FRAME_CYC = 2 * DEF_DIV * DEF_DATA_W + DEF_DIV;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_SHIFT_LO = 2'd1;
    localparam state_t ST_SHIFT_HI = 2'd2;
    localparam state_t ST_LATCH    = 2'd3;

    // Ceiling log2, used to size counters at elaboration time.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_shift_driver_if.sv
// Frame request handshake between the output-port register and the LED driver.
interface led_shift_driver_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/led_phase_timer.sv
// DIV-cycle phase timer: o_done is high in the last cycle of a phase.
module led_phase_timer
    import led_drv_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_done
);
    localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);

    logic [CNT_W-1:0] cnt;

    // Reload on every phase start, then count down and park at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_start) begin
            cnt <= CNT_W'(DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_done = (cnt == '0);

endmodule

// File: rtl/led_shift_driver.sv
// Serial driver for a chain of 74HC595-style LED shift registers.
//
// state    | meaning
// IDLE     | ready for a new frame, or re-sends the stored one on refresh
// SHIFT_LO | serial clock low, current bit presented on o_data
// SHIFT_HI | serial clock high, receivers sample o_data
// LATCH    | latch pulse transfers the shifted frame to the LED outputs
module led_shift_driver
    import led_drv_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int DIV           = DEF_DIV,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit LATCH_ACT_LOW = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    led_shift_driver_if.slave bus,
    input  logic              i_refresh_en,
    output logic              o_sclk,
    output logic              o_data,
    output logic              o_latch,
    output logic              o_busy
);
    localparam int IDX_W = clog2(DATA_W);
    localparam logic LATCH_ON  = ~LATCH_ACT_LOW;
    localparam logic LATCH_OFF = LATCH_ACT_LOW;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] frame;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nx;
    logic              accept;
    logic              phase_start;
    logic              phase_done;

    // Bit index counts transmission order; map it onto the frame per shift direction.
    function automatic logic pick_bit(input logic [DATA_W-1:0] f, input logic [IDX_W-1:0] i);
        if (MSB_FIRST) begin
            return f[IDX_LAST - i];
        end
        return f[i];
    endfunction

    assign accept      = bus.i_valid && (state == ST_IDLE);
    assign bus.o_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);
    assign idx_nx      = idx + 1'b1;

    led_phase_timer #(
        .DIV(DIV)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(phase_start),
        .o_done (phase_done)
    );

    // Next state and phase-timer restart; every timed phase is entered with a fresh start.
    always_comb begin
        state_nx    = state;
        phase_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept || i_refresh_en) begin
                    state_nx    = ST_SHIFT_LO;
                    phase_start = 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_done) begin
                    state_nx    = ST_SHIFT_HI;
                    phase_start = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_done) begin
                    state_nx    = (idx == IDX_LAST) ? ST_LATCH : ST_SHIFT_LO;
                    phase_start = 1'b1;
                end
            end
            ST_LATCH: begin
                if (phase_done) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, frame store, bit index and registered pin outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            frame   <= '0;
            idx     <= '0;
            o_sclk  <= 1'b0;
            o_data  <= 1'b0;
            o_latch <= LATCH_OFF;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        frame  <= bus.i_data;
                        idx    <= '0;
                        o_data <= pick_bit(bus.i_data, '0);
                    end else if (i_refresh_en) begin
                        idx    <= '0;
                        o_data <= pick_bit(frame, '0);
                    end
                end
                ST_SHIFT_LO: begin
                    if (phase_done) begin
                        o_sclk <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_done) begin
                        o_sclk <= 1'b0;
                        if (idx == IDX_LAST) begin
                            o_latch <= LATCH_ON;
                        end else begin
                            idx    <= idx_nx;
                            o_data <= pick_bit(frame, idx_nx);
                        end
                    end
                end
                ST_LATCH: begin
                    if (phase_done) begin
                        o_latch <= LATCH_OFF;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/led_shift_driver.md
Name: led_shift_driver

Overview:
- Parametrised serial driver for daisy-chained 74HC595-style LED shift registers on the Spartan6 board.
- Accepts a parallel LED frame over a valid/ready handshake, then shifts it out with a generated serial clock and a latch pulse.
- Optional auto-refresh re-sends the last frame.
- Sits between the processor's output-port register and the board LED pins.
- Successor of the fixed 16-bit free-running LED driver.

Parameters:
- DATA_W, 16: bits per frame, i.e. total LED count across the chain; must be >= 2.
- DIV, 2: system clocks per serial-clock half period; must be >= 1.
- MSB_FIRST, 1: 1 shifts i_data[DATA_W-1] first; 0 shifts i_data[0] first.
- LATCH_ACT_LOW, 1: latch pulse polarity; 1 means o_latch idles high and pulses low.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  DATA_W  frame to display; sampled only on the accept edge.
- i_valid  in  1  frame request.
- o_ready  out  1  high only in IDLE; accept = i_valid & o_ready.
- i_refresh_en  in  1  when high, an idle driver re-sends the stored frame.
- o_sclk  out  1  serial shift clock; data is shifted on its rising edge.
- o_data  out  1  serial data.
- o_latch  out  1  storage latch pulse.
- o_busy  out  1  high while a frame (shift or latch phase) is in progress.

Behaviour:
- Reset values:
  - o_sclk=0, o_data=0, o_latch=inactive (1 when LATCH_ACT_LOW=1), o_busy=0.
  - Frame register cleared to 0; state=IDLE.
  - o_ready=1 from the first cycle after i_rst deasserts.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - On accept, capture i_data into the frame register and go to SHIFT_LO with bit index 0.
  - Else if i_refresh_en=1, go to SHIFT_LO using the stored frame.
  - If i_valid and i_refresh_en are both high, the new data wins.
  - o_ready=0 and o_busy=1 in every non-IDLE state.
- SHIFT_LO: lasts DIV cycles.
  - o_sclk=0.
  - o_data = current bit, selected per MSB_FIRST; it changes only on entry to SHIFT_LO.
- SHIFT_HI: lasts DIV cycles.
  - o_sclk=1, o_data held stable.
  - At exit: if the bit index is DATA_W-1, go to LATCH; else increment the index and go to SHIFT_LO.
- LATCH: lasts DIV cycles.
  - o_sclk=0, o_latch=active.
  - Then IDLE, where o_latch returns to inactive and o_ready=1.
- Latency:
  - First bit appears on o_data the cycle after the accept edge.
  - o_ready stays low for exactly 2*DIV*DATA_W + DIV cycles (66 at defaults).
- Data stability:
  - i_data and i_valid changes mid-frame are ignored.
  - No request queueing: a request held during a frame is accepted on the first IDLE cycle.
- Back-to-back frames: at most one IDLE cycle between a latch pulse end and the next frame's first bit.
- Counters:
  - Divider counter width is clog2(DIV) bits, minimum 1.
  - Bit index width is clog2(DATA_W) bits.
  - Neither counter wraps past its terminal value; each resets on phase change.
- Reset mid-operation: takes effect on the next edge.
  - Outputs go to their reset values and no latch pulse is emitted.
  - A partially shifted frame is discarded.
  - o_ready=1 on the cycle after reset deasserts.
- The frame register persists across frames until the next accept or reset; refresh uses it.

Decomposition:
- Shared package/include led_drv_pkg holds:
  - state encodings (IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3);
  - a clog2 function;
  - the frame-length localparam FRAME_CYC = 2*DIV*DATA_W + DIV.
- One natural sub-module, led_phase_timer: a DIV-cycle down-counter with i_rst, i_start, o_done.
  - It is reused for all three timed phases.
- FSM, bit index and output registers stay in led_shift_driver.

Test Plan:
- Reset, then idle for 20 cycles with i_valid=0 and i_refresh_en=0 -> o_sclk=0, o_data=0, o_latch=1, o_ready=1, o_busy=0 throughout.
- Defaults, accept i_data=16'hA5C3 -> o_data samples at the 16 o_sclk rising edges are 1010_0101_1100_0011; exactly one o_latch low pulse of 2 cycles after the 16th edge; o_ready low for 66 cycles.
- MSB_FIRST=0, DATA_W=8, DIV=1, i_data=8'h01 -> first sampled bit 1, remaining seven 0; frame length 17 cycles.
- Hold i_valid=1 with 16'hFFFF, then 16'h0000 presented immediately -> second frame starts at most 1 cycle after the first latch pulse; 16'h1234 driven mid-frame is ignored.
- i_refresh_en=1 after one accept of 16'h00FF -> identical frames repeat back-to-back; asserting i_valid=1 with 16'hF00F in the IDLE cycle replaces the content.
- Assert i_rst at bit 7 of a frame -> next cycle all outputs at reset values, no latch pulse ever occurs for that frame, o_ready=1 after deassert.
